// File: rtl/layer_control_responder.sv
// Layer-side responder for the master_controller control bus.
// Registers the broadcast phase code, starts a phase on each new non-idle
// code and sequences load / MAC / activation / write-back for one layer.
module layer_control_responder #(
   parameter int max      = 5,
   parameter int layer_no = 4,
   parameter int IDX_W    = $clog2(max),
   parameter int LAY_W    = (layer_no > 1) ? $clog2(layer_no) : 1,
   parameter int WADDR_W  = $clog2(max * max * layer_no)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         control,
   output logic [IDX_W-1:0]   in_addr,
   output logic [WADDR_W-1:0] w_addr,
   output logic [IDX_W-1:0]   neuron_idx,
   output logic [LAY_W-1:0]   layer_idx,
   output logic               load_en,
   output logic               acc_clr,
   output logic               mac_en,
   output logic               act_en,
   output logic               wb_en,
   output logic               phase_done,
   output logic               net_done,
   output logic               abort,
   output logic               err
);

   typedef enum logic [2:0] {
      C_IDLE    = 3'b000,
      C_LOAD    = 3'b001,
      C_COMPUTE = 3'b010,
      C_ACT     = 3'b011,
      C_WB      = 3'b100,
      C_NEXT    = 3'b101,
      C_DONE    = 3'b110,
      C_ILLEGAL = 3'b111
   } code_t;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_COMPUTE, S_ACT, S_WB, S_NEXT, S_HOLD, S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(max - 1);
   localparam logic [LAY_W-1:0] LAST_LAYER = LAY_W'(layer_no - 1);

   state_t             state, state_n;
   logic [2:0]         control_q;
   logic [IDX_W-1:0]   i, i_n, j, j_n;
   logic [LAY_W-1:0]   layer, layer_n;
   logic [WADDR_W-1:0] w_addr_n;
   logic               load_en_n, acc_clr_n, mac_en_n, act_en_n, wb_en_n;
   logic               phase_done_n, net_done_n, abort_n, err_n;
   logic               change, active, fin;

   assign in_addr    = i;
   assign neuron_idx = j;
   assign layer_idx  = layer;

   // State, counters and all strobes are registered together from next values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         control_q  <= 3'b000;
         i          <= '0;
         j          <= '0;
         layer      <= '0;
         w_addr     <= '0;
         load_en    <= 1'b0;
         acc_clr    <= 1'b0;
         mac_en     <= 1'b0;
         act_en     <= 1'b0;
         wb_en      <= 1'b0;
         phase_done <= 1'b0;
         net_done   <= 1'b0;
         abort      <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         control_q  <= control;
         i          <= i_n;
         j          <= j_n;
         layer      <= layer_n;
         w_addr     <= w_addr_n;
         load_en    <= load_en_n;
         acc_clr    <= acc_clr_n;
         mac_en     <= mac_en_n;
         act_en     <= act_en_n;
         wb_en      <= wb_en_n;
         phase_done <= phase_done_n;
         net_done   <= net_done_n;
         abort      <= abort_n;
         err        <= err_n;
      end
   end

   // Next-state, counter and strobe decode; a new code overrides any running phase.
   always_comb begin
      state_n      = state;
      i_n          = i;
      j_n          = j;
      layer_n      = layer;
      load_en_n    = 1'b0;
      acc_clr_n    = 1'b0;
      mac_en_n     = 1'b0;
      act_en_n     = 1'b0;
      wb_en_n      = 1'b0;
      phase_done_n = 1'b0;
      net_done_n   = 1'b0;
      abort_n      = 1'b0;
      err_n        = err;
      fin          = 1'b0;
      change       = (control != control_q);
      active       = (state == S_LOAD) || (state == S_COMPUTE) || (state == S_ACT) ||
                     (state == S_WB) || (state == S_NEXT);

      if (state == S_DONE) begin
         // Only a return to idle releases DONE; that is also the one path that clears the layer.
         if (control == 3'b000) begin
            state_n = S_IDLE;
            i_n     = '0;
            j_n     = '0;
            layer_n = '0;
         end else begin
            net_done_n = 1'b1;
         end
      end else if (change) begin
         abort_n = active;
         i_n     = '0;
         j_n     = '0;
         case (code_t'(control))
            C_IDLE:    state_n = S_IDLE;
            C_LOAD:    begin state_n = S_LOAD; load_en_n = 1'b1; end
            C_COMPUTE: begin state_n = S_COMPUTE; mac_en_n = 1'b1; acc_clr_n = 1'b1; end
            C_ACT:     begin state_n = S_ACT; act_en_n = 1'b1; end
            C_WB:      begin state_n = S_WB; wb_en_n = 1'b1; end
            C_NEXT:    begin
               state_n = S_NEXT;
               layer_n = (layer == LAST_LAYER) ? '0 : layer + LAY_W'(1);
            end
            C_DONE:    begin state_n = S_DONE; net_done_n = 1'b1; end
            default:   begin state_n = S_HOLD; err_n = 1'b1; end
         endcase
      end else begin
         case (state)
            S_LOAD: begin
               if (i == LAST_IDX) fin = 1'b1;
               else begin i_n = i + IDX_W'(1); load_en_n = 1'b1; end
            end
            S_COMPUTE: begin
               if (i == LAST_IDX) begin
                  if (j == LAST_IDX) fin = 1'b1;
                  else begin
                     i_n       = '0;
                     j_n       = j + IDX_W'(1);
                     mac_en_n  = 1'b1;
                     acc_clr_n = 1'b1;
                  end
               end else begin
                  i_n      = i + IDX_W'(1);
                  mac_en_n = 1'b1;
               end
            end
            S_ACT: begin
               if (j == LAST_IDX) fin = 1'b1;
               else begin j_n = j + IDX_W'(1); act_en_n = 1'b1; end
            end
            S_WB: begin
               if (j == LAST_IDX) fin = 1'b1;
               else begin j_n = j + IDX_W'(1); wb_en_n = 1'b1; end
            end
            S_NEXT:  fin = 1'b1;
            default: ;
         endcase
      end

      if (fin) begin
         state_n      = S_HOLD;
         phase_done_n = 1'b1;
         i_n          = '0;
         j_n          = '0;
      end

      w_addr_n = mac_en_n ? (WADDR_W'(layer_n) * WADDR_W'(max * max) +
                             WADDR_W'(j_n) * WADDR_W'(max) + WADDR_W'(i_n)) : '0;
   end

endmodule

// File: tb/tb_layer_control_responder.sv
// Scoreboard bench for layer_control_responder: each issued command pushes its
// expected per-cycle activity; a negedge monitor pops and compares it.
module tb_layer_control_responder;

   localparam int MAX     = 5;
   localparam int LAYERS  = 4;
   localparam int IDX_W   = $clog2(MAX);
   localparam int LAY_W   = (LAYERS > 1) ? $clog2(LAYERS) : 1;
   localparam int WADDR_W = $clog2(MAX * MAX * LAYERS);

   logic               clk = 1'b0;
   logic               rst_n;
   logic [2:0]         control;
   logic [IDX_W-1:0]   in_addr;
   logic [WADDR_W-1:0] w_addr;
   logic [IDX_W-1:0]   neuron_idx;
   logic [LAY_W-1:0]   layer_idx;
   logic               load_en, acc_clr, mac_en, act_en, wb_en;
   logic               phase_done, net_done, abort, err;

   layer_control_responder #(.max(MAX), .layer_no(LAYERS)) dut (
      .clk(clk), .rst_n(rst_n), .control(control),
      .in_addr(in_addr), .w_addr(w_addr), .neuron_idx(neuron_idx), .layer_idx(layer_idx),
      .load_en(load_en), .acc_clr(acc_clr), .mac_en(mac_en), .act_en(act_en), .wb_en(wb_en),
      .phase_done(phase_done), .net_done(net_done), .abort(abort), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit        load, clr, mac, act, wb, pd, net, ab, err;
      bit [31:0] in_a, neu, wa, lay;
   } rec_t;

   rec_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // model state
   int         m_layer = 0;
   bit         m_err   = 1'b0;
   logic [2:0] prev_code = 3'b000;
   int         prev_d    = 0;

   function automatic bit is_event(rec_t r);
      return r.load | r.clr | r.mac | r.act | r.wb | r.pd | r.net | r.ab |
             (r.in_a != 0) | (r.neu != 0) | (r.wa != 0);
   endfunction

   function automatic string fmt(rec_t r);
      return $sformatf("ld=%0d clr=%0d mac=%0d act=%0d wb=%0d pd=%0d net=%0d ab=%0d err=%0d in=%0d n=%0d w=%0d lay=%0d",
                       r.load, r.clr, r.mac, r.act, r.wb, r.pd, r.net, r.ab, r.err,
                       r.in_a, r.neu, r.wa, r.lay);
   endfunction

   // Cycles a phase keeps its strobes active; 0 means the code has no interruptible phase.
   function automatic int phase_len(logic [2:0] c);
      case (c)
         3'b001, 3'b011, 3'b100: return MAX;
         3'b010:                 return MAX * MAX;
         3'b101:                 return 1;
         default:                return 0;
      endcase
   endfunction

   // Monitor: any cycle with visible activity must match the next expected record.
   always @(negedge clk) begin
      rec_t got;
      rec_t e;
      got      = '0;
      got.load = load_en;   got.clr = acc_clr;  got.mac = mac_en;
      got.act  = act_en;    got.wb  = wb_en;    got.pd  = phase_done;
      got.net  = net_done;  got.ab  = abort;    got.err = err;
      got.in_a = 32'(in_addr);
      got.neu  = 32'(neuron_idx);
      got.wa   = 32'(w_addr);
      got.lay  = 32'(layer_idx);
      if (is_event(got)) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_activity got {%s} required {none}", fmt(got));
         end else begin
            e = exp_q.pop_front();
            if (got != e) begin
               fails++;
               $display("FAIL activity got {%s} required {%s}", fmt(got), fmt(e));
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s got %0d required %0d", name, act, req);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_addr"}, int'(in_addr), 0);
      chk({tag, "_w_addr"}, int'(w_addr), 0);
      chk({tag, "_neuron_idx"}, int'(neuron_idx), 0);
      chk({tag, "_layer_idx"}, int'(layer_idx), 0);
      chk({tag, "_strobes"}, int'({load_en, acc_clr, mac_en, act_en, wb_en}), 0);
      chk({tag, "_phase_done"}, int'(phase_done), 0);
      chk({tag, "_net_done"}, int'(net_done), 0);
      chk({tag, "_abort"}, int'(abort), 0);
      chk({tag, "_err"}, int'(err), 0);
   endtask

   // Drive code c for d sampled edges, pushing the activity expected in each of those cycles.
   task automatic issue(input logic [2:0] c, input int d);
      int   pl, len;
      bit   ab0;
      rec_t r;
      pl  = phase_len(prev_code);
      ab0 = (pl > 0) && (prev_d <= pl);
      if (c == 3'b101) m_layer = (m_layer + 1) % LAYERS;
      if (c == 3'b000 && prev_code == 3'b110) m_layer = 0;
      if (c == 3'b111) m_err = 1'b1;
      len = phase_len(c);
      for (int k = 0; k < d; k++) begin
         r     = '0;
         r.lay = 32'(m_layer);
         r.err = m_err;
         r.ab  = (k == 0) && ab0;
         case (c)
            3'b001: if (k < len) begin r.load = 1; r.in_a = 32'(k); end
                    else if (k == len) r.pd = 1;
            3'b010: if (k < len) begin
                       r.mac  = 1;
                       r.in_a = 32'(k % MAX);
                       r.neu  = 32'(k / MAX);
                       r.clr  = (k % MAX == 0);
                       r.wa   = 32'(m_layer * MAX * MAX + k);
                    end else if (k == len) r.pd = 1;
            3'b011: if (k < len) begin r.act = 1; r.neu = 32'(k); end
                    else if (k == len) r.pd = 1;
            3'b100: if (k < len) begin r.wb = 1; r.neu = 32'(k); end
                    else if (k == len) r.pd = 1;
            3'b101: if (k == len) r.pd = 1;
            3'b110: r.net = 1;
            default: ;
         endcase
         if (is_event(r)) exp_q.push_back(r);
      end
      prev_code = c;
      prev_d    = d;
      control   = c;
      repeat (d) @(posedge clk);
      #2;
   endtask

   initial begin
      logic [2:0] c;
      int         d, len;
      rst_n   = 1'b0;
      control = 3'b000;
      repeat (3) @(posedge clk);
      #2;
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      // load, then full compute at layer 0
      issue(3'b001, 8);
      issue(3'b010, 28);
      // four layer advances separated by idle, wrapping back to 0
      for (int n = 0; n < 4; n++) begin
         issue(3'b000, 2);
         issue(3'b101, 3);
         chk("layer_after_next", int'(layer_idx), m_layer);
      end
      chk("layer_wrapped", int'(layer_idx), 0);
      issue(3'b000, 2); issue(3'b101, 2);
      issue(3'b000, 2); issue(3'b101, 2);
      chk("layer_two", int'(layer_idx), 2);
      issue(3'b010, 28);
      // compute interrupted by activate
      issue(3'b000, 2);
      issue(3'b010, 7);
      issue(3'b011, 8);
      // illegal code, then load, then done
      issue(3'b111, 3);
      chk("err_sticky", int'(err), 1);
      issue(3'b001, 7);
      issue(3'b110, 4);
      issue(3'b000, 3);
      chk("layer_after_done", int'(layer_idx), 0);
      chk("err_still_set", int'(err), 1);
      // reset during write-back at neuron 2
      issue(3'b100, 3);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      control   = 3'b000;
      m_layer   = 0;
      m_err     = 1'b0;
      prev_code = 3'b000;
      prev_d    = 0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("idle_after_reset_layer", int'(layer_idx), 0);

      // randomized command stream with both completed and interrupted phases
      for (int n = 0; n < 80; n++) begin
         if (prev_code == 3'b110) c = 3'b000;
         else begin
            c = 3'($urandom_range(0, 7));
            while (c == prev_code || (c == 3'b111 && $urandom_range(0, 3) != 0))
               c = 3'($urandom_range(0, 7));
         end
         len = phase_len(c);
         if (len > 0)
            d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len))
                                            : len + int'($urandom_range(1, 3));
         else
            d = int'($urandom_range(1, 4));
         issue(c, d);
      end
      if (prev_code != 3'b000) issue(3'b000, 4);
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
